life_board_reader: RTL and testbench



---
 rtl/life_board_reader_pkg.sv | 34 +++
 rtl/life_row_popcount.sv | 28 ++
 rtl/life_board_reader.sv | 122 ++++++++++++
 tb/tb_life_board_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_board_reader_pkg.sv
// ============================================================================
// Module   : life_board_reader_pkg
// Brief    : Shared board constants, reader FSM states and width helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package life_board_reader_pkg;

  localparam int c_DEFAULT_ROWS = 8;
  localparam int c_DEFAULT_COLS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } reader_state_t;

  // A one-row board still needs a 1-bit index port.
  function automatic int idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int cnt_width(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  function automatic int pop_width(input int cols);
    return $clog2(cols + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/life_row_popcount.sv
// ============================================================================
// Module   : life_row_popcount
// Brief    : Combinational population count of one board row.
// Revision : 1.0
// ============================================================================
`default_nettype none

module life_row_popcount
  import life_board_reader_pkg::*;
#(
  parameter int COLS = c_DEFAULT_COLS
) (
  input  logic [COLS-1:0]             row,
  output logic [pop_width(COLS)-1:0]  count
);

  localparam int c_POP_W = pop_width(COLS);

  always_comb begin
    count = '0;
    for (int i = 0; i < COLS; i++) begin
      count = count + c_POP_W'(row[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/life_board_reader.sv
// ============================================================================
// Module   : life_board_reader
// Brief    : Snapshots the board and streams it row by row, counting live cells.
// Revision : 1.0
// ============================================================================
`default_nettype none

module life_board_reader
  import life_board_reader_pkg::*;
#(
  parameter int ROWS = c_DEFAULT_ROWS,
  parameter int COLS = c_DEFAULT_COLS
) (
  input  logic                               clk,
  input  logic                               _rst,
  input  logic [ROWS*COLS-1:0]               cells,
  input  logic                               start,
  output logic [COLS-1:0]                    row_data,
  output logic [idx_width(ROWS)-1:0]         row_idx,
  output logic                               row_valid,
  input  logic                               row_ready,
  output logic                               last_row,
  output logic                               busy,
  output logic                               frame_done,
  output logic [cnt_width(ROWS, COLS)-1:0]   live_total
);

  localparam int c_IDX_W = idx_width(ROWS);
  localparam int c_CNT_W = cnt_width(ROWS, COLS);
  localparam int c_POP_W = pop_width(COLS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ROWS - 1);

  reader_state_t        r_state;
  reader_state_t        w_state_next;
  logic [COLS-1:0]      r_snap [ROWS];
  logic [c_IDX_W-1:0]   r_row_idx;
  logic [c_CNT_W-1:0]   r_live_total;
  logic [c_POP_W-1:0]   w_pop;
  logic                 w_capture;
  logic                 w_xfer;
  logic                 w_at_last;

  assign w_at_last = (r_row_idx == c_LAST_IDX);
  assign row_data  = r_snap[r_row_idx];
  assign row_idx   = r_row_idx;
  assign live_total = r_live_total;

  life_row_popcount #(
    .COLS (COLS)
  ) u_popcount (
    .row   (row_data),
    .count (w_pop)
  );

  always_ff @(posedge clk) begin
    if (!_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    row_valid    = 1'b0;
    last_row     = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        row_valid = 1'b1;
        busy      = 1'b1;
        last_row  = w_at_last;
        w_xfer    = row_ready;
        if (row_ready && w_at_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        frame_done   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // The index stays on the last row after a frame so row_data keeps its last value in IDLE.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      r_row_idx    <= '0;
      r_live_total <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_snap[r] <= '0;
      end
    end else if (w_capture) begin
      r_row_idx    <= '0;
      r_live_total <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_snap[r] <= cells[r*COLS +: COLS];
      end
    end else if (w_xfer) begin
      r_live_total <= r_live_total + c_CNT_W'(w_pop);
      if (!w_at_last) begin
        r_row_idx <= r_row_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_life_board_reader.sv
// Bench for life_board_reader: a 4x4 instance and a 1x8 instance checked against
// row slices and live-cell counts computed directly from the captured board word.
`default_nettype none

module tb_life_board_reader;

  localparam int R = 4;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [R*C-1:0] cells;
  logic           start, row_ready;
  logic [C-1:0]   row_data;
  logic [1:0]     row_idx;
  logic           row_valid, last_row, busy, frame_done;
  logic [4:0]     live_total;

  logic [7:0]     cells1;
  logic           start1, ready1;
  logic [7:0]     data1;
  logic [0:0]     idx1;
  logic           valid1, last1, busy1, done1;
  logic [3:0]     live1;

  life_board_reader #(.ROWS(R), .COLS(C)) dut (
    .clk(clk), ._rst(rst_n), .cells(cells), .start(start),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .row_ready(row_ready), .last_row(last_row), .busy(busy),
    .frame_done(frame_done), .live_total(live_total)
  );

  life_board_reader #(.ROWS(1), .COLS(8)) dut1 (
    .clk(clk), ._rst(rst_n), .cells(cells1), .start(start1),
    .row_data(data1), .row_idx(idx1), .row_valid(valid1),
    .row_ready(ready1), .last_row(last1), .busy(busy1),
    .frame_done(done1), .live_total(live1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [C-1:0] got_data[$];
  int           got_idx[$];
  bit           got_last[$];
  int           stall_breaks;
  int           valid_low;

  function automatic logic [C-1:0] exp_row(input logic [R*C-1:0] board, input int r);
    logic [R*C-1:0] shifted;
    shifted = board >> (r * C);
    return shifted[C-1:0];
  endfunction

  function automatic int exp_total(input logic [R*C-1:0] board);
    return $countones(board);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [R*C-1:0] board);
    cells = board;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Accepts rows until last_row transfers; leaves time in the cycle after the last transfer.
  task automatic receive_frame(input int stall_idx, input int stall_len, input bit rand_ready,
                               output bit timed_out, output int cycles);
    bit           done;
    bit           prev_stall;
    int           stalled;
    logic [C-1:0] pd;
    logic [1:0]   pi;
    got_data.delete(); got_idx.delete(); got_last.delete();
    stall_breaks = 0; valid_low = 0;
    done = 0; prev_stall = 0; stalled = 0; cycles = 0; pd = '0; pi = '0;
    while (!done && cycles < 200) begin
      if (prev_stall && (row_data !== pd || row_idx !== pi)) stall_breaks++;
      if (row_valid !== 1'b1) valid_low++;
      if (rand_ready) row_ready = 1'($urandom_range(0, 1));
      else if (int'(row_idx) == stall_idx && stalled < stall_len) begin
        row_ready = 1'b0;
        stalled++;
      end else row_ready = 1'b1;
      prev_stall = (row_valid === 1'b1) && !row_ready;
      pd = row_data; pi = row_idx;
      if (row_valid === 1'b1 && row_ready) begin
        got_data.push_back(row_data);
        got_idx.push_back(int'(row_idx));
        got_last.push_back(last_row);
        if (last_row === 1'b1 || got_data.size() >= R) done = 1;
      end
      tick();
      cycles++;
    end
    row_ready = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; row_ready = 1'b0; cells = '0;
    start1 = 1'b0; ready1 = 1'b0; cells1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_checks++;
    if ({row_valid, last_row, busy, frame_done} !== 4'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 0000", {row_valid, last_row, busy, frame_done});
    end
    n_checks++;
    if (row_idx !== 2'd0 || row_data !== 4'h0 || live_total !== 5'd0) begin
      n_errors++; $display("FAIL reset_values: got idx %0d data %h live %0d expected 0 0 0", row_idx, row_data, live_total);
    end
    n_checks++;
    if ({valid1, busy1, done1, live1} !== 7'b0) begin
      n_errors++; $display("FAIL reset_single: got %b expected 0", {valid1, busy1, done1, live1});
    end
  endtask

  task automatic test_glider();
    bit to; int cyc;
    launch(16'h0742);
    receive_frame(-1, 0, 0, to, cyc);
    n_checks++;
    if (to || got_data.size() != R || cyc != R) begin
      n_errors++; $display("FAIL glider_count: got %0d rows in %0d cycles expected %0d in %0d", got_data.size(), cyc, R, R);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_row(16'h0742, i) || got_idx[i] != i || got_last[i] !== (i == R-1)) begin
        n_errors++; $display("FAIL glider_row%0d: got data %h idx %0d last %b expected %h %0d %b",
                             i, got_data[i], got_idx[i], got_last[i], exp_row(16'h0742, i), i, (i == R-1));
      end
    end
    n_checks++;
    if (frame_done !== 1'b1 || row_valid !== 1'b0 || busy !== 1'b1 || live_total !== 5'd5) begin
      n_errors++; $display("FAIL glider_done: got done %b valid %b busy %b live %0d expected 1 0 1 5",
                           frame_done, row_valid, busy, live_total);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || live_total !== 5'd5) begin
      n_errors++; $display("FAIL glider_idle: got done %b busy %b live %0d expected 0 0 5", frame_done, busy, live_total);
    end
  endtask

  task automatic test_backpressure();
    bit to; int cyc;
    launch(16'h0742);
    receive_frame(1, 3, 0, to, cyc);
    n_checks++;
    if (to || stall_breaks != 0 || valid_low != 0 || cyc != R + 3) begin
      n_errors++; $display("FAIL backpressure_hold: got breaks %0d valid_low %0d cycles %0d expected 0 0 %0d",
                           stall_breaks, valid_low, cyc, R + 3);
    end
    n_checks++;
    if (got_data.size() != R || got_data[1] !== 4'h4 || frame_done !== 1'b1 || live_total !== 5'd5) begin
      n_errors++; $display("FAIL backpressure_frame: got rows %0d done %b live %0d expected %0d 1 5",
                           got_data.size(), frame_done, live_total, R);
    end
    tick();
  endtask

  task automatic test_snapshot_isolation();
    bit to; int cyc;
    launch(16'hFFFF);
    cells = 16'h0000;
    receive_frame(-1, 0, 0, to, cyc);
    for (int i = 0; i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== 4'hF) begin
        n_errors++; $display("FAIL snapshot_row%0d: got %h expected f", i, got_data[i]);
      end
    end
    n_checks++;
    if (to || got_data.size() != R || live_total !== 5'd16) begin
      n_errors++; $display("FAIL snapshot_total: got rows %0d live %0d expected %0d 16", got_data.size(), live_total, R);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    bit to; int cyc;
    cells = 16'h3C81;
    start = 1'b1;
    tick();
    receive_frame(-1, 0, 0, to, cyc);
    n_checks++;
    if (to || got_data.size() != R || frame_done !== 1'b1 || live_total !== 5'(exp_total(16'h3C81))) begin
      n_errors++; $display("FAIL busy_frame: got rows %0d done %b live %0d expected %0d 1 %0d",
                           got_data.size(), frame_done, live_total, R, exp_total(16'h3C81));
    end
    tick();
    n_checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_not_queued: got valid %b busy %b expected 0 0", row_valid, busy);
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || live_total !== 5'(exp_total(16'h3C81))) begin
      n_errors++; $display("FAIL busy_idle_hold: got valid %b busy %b live %0d", row_valid, busy, live_total);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to; int cyc; int n_fd;
    launch(16'h0742);
    row_ready = 1'b1;
    tick(); tick();
    row_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || live_total !== 5'd0 || frame_done !== 1'b0) begin
      n_errors++; $display("FAIL midreset_state: got valid %b busy %b live %0d done %b expected 0 0 0 0",
                           row_valid, busy, live_total, frame_done);
    end
    rst_n = 1'b1;
    n_fd = 0;
    repeat (3) begin
      if (frame_done !== 1'b0 || row_valid !== 1'b0) n_fd++;
      tick();
    end
    n_checks++;
    if (n_fd != 0) begin
      n_errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", n_fd);
    end
    launch(16'hA5C3);
    receive_frame(-1, 0, 0, to, cyc);
    n_checks++;
    if (to || got_data.size() != R || got_data[0] !== 4'h3 || got_data[3] !== 4'hA || live_total !== 5'd8) begin
      n_errors++; $display("FAIL midreset_refill: got rows %0d live %0d expected %0d 8", got_data.size(), live_total, R);
    end
    tick();
  endtask

  task automatic test_random();
    bit to; int cyc; logic [R*C-1:0] board;
    for (int f = 0; f < 8; f++) begin
      board = 16'($urandom);
      launch(board);
      cells = 16'($urandom);
      receive_frame(-1, 0, 1, to, cyc);
      for (int i = 0; i < got_data.size(); i++) begin
        n_checks++;
        if (got_data[i] !== exp_row(board, i) || got_idx[i] != i || got_last[i] !== (i == R-1)) begin
          n_errors++; $display("FAIL random%0d_row%0d: got %h idx %0d expected %h idx %0d",
                               f, i, got_data[i], got_idx[i], exp_row(board, i), i);
        end
      end
      n_checks++;
      if (to || stall_breaks != 0 || frame_done !== 1'b1 || live_total !== 5'(exp_total(board))) begin
        n_errors++; $display("FAIL random%0d_total: got live %0d done %b breaks %0d expected %0d 1 0",
                             f, live_total, frame_done, stall_breaks, exp_total(board));
      end
      tick();
    end
  endtask

  task automatic test_single_row();
    cells1 = 8'hA5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cells1 = 8'h00;
    n_checks++;
    if (valid1 !== 1'b1 || last1 !== 1'b1 || idx1 !== 1'b0 || data1 !== 8'hA5) begin
      n_errors++; $display("FAIL single_offer: got valid %b last %b idx %0d data %h expected 1 1 0 a5",
                           valid1, last1, idx1, data1);
    end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    n_checks++;
    if (done1 !== 1'b1 || valid1 !== 1'b0 || live1 !== 4'd4) begin
      n_errors++; $display("FAIL single_done: got done %b valid %b live %0d expected 1 0 4", done1, valid1, live1);
    end
    tick();
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || live1 !== 4'd4) begin
      n_errors++; $display("FAIL single_idle: got done %b busy %b live %0d expected 0 0 4", done1, busy1, live1);
    end
  endtask

  initial begin
    test_reset();
    test_glider();
    test_backpressure();
    test_snapshot_isolation();
    test_start_while_busy();
    test_reset_mid_frame();
    test_random();
    test_single_row();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
